obstacle_scheduler: RTL

- Spawn controller for the bird and cactus obstacle engines in dinorun.
- Sits between the LFSR, the game-state FSM and the two obstacle blocks.
- Converts random spawn requests into at most one granted spawn per frame.
- Enforces a minimum frame gap between obstacles, skips busy targets, and ramps difficulty by shrinking the gap over play time.

---
 rtl/obstacle_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/obstacle_scheduler.sv
// Spawn scheduler for bird/cactus obstacles: one grant per frame max, min frame gap, level ramp.
// Latency: spawn pulses are Mealy, same cycle as the frame tick; state/level update next cycle.
// Backpressure: a busy target blocks its grant (no redirect); freeze_i holds everything.
// Optional: define OBSTACLE_SCHED_FORCE_EN to force a spawn after MAX_WAIT_FRAMES armed frames.
module obstacle_scheduler #(
    parameter int MIN_GAP_INIT      = 60,
    parameter int MIN_GAP_FLOOR     = 20,
    parameter int GAP_DEC           = 4,
    parameter int LEVEL_STEP_FRAMES = 600,
    parameter int MAX_WAIT_FRAMES   = 90
) (
    input  logic        clk_25_175_i,
    input  logic        rst_i,
    input  logic        run_i,
    input  logic        freeze_i,
    input  logic        next_frame_i,
    input  logic [15:0] rand_i,
    input  logic        bird_busy_i,
    input  logic        cactus_busy_i,
    output logic        bird_spawn_o,
    output logic        cactus_spawn_o,
    output logic [3:0]  level_o,
    output logic        armed_o
);

    localparam int FC_W = $clog2(LEVEL_STEP_FRAMES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COOLDOWN = 2'd1,
        ARMED    = 2'd2
    } state_t;

    state_t            state;
    logic [7:0]        gap_cnt;
    logic [7:0]        wait_cnt;
    logic [FC_W-1:0]   frame_cnt;
    logic [3:0]        level;
    logic              last_bird;   // 1: last grant was bird, 0: cactus

    logic              tick;
    logic              armed_tick;
    logic [7:0]        gap_dec;
    logic [7:0]        cur_gap;
    logic              rnd_bird;
    logic              rnd_cactus;
    logic              force_bird;
    logic              force_cactus;
    logic              force_stall;
    logic              grant_bird;
    logic              grant_cactus;
    logic              unused_bits;

    assign tick       = next_frame_i & run_i & ~freeze_i;
    assign armed_tick = tick & (state == ARMED);

    // Cooldown length for the current level, clamped before subtracting so it never underflows
    always_comb begin
        gap_dec = 8'(level) * 8'(GAP_DEC);
        if (gap_dec >= 8'(MIN_GAP_INIT - MIN_GAP_FLOOR)) begin
            cur_gap = 8'(MIN_GAP_FLOOR);
        end else begin
            cur_gap = 8'(MIN_GAP_INIT) - gap_dec;
        end
    end

    // Random request decode; a busy target simply loses the request
    always_comb begin
        rnd_bird   = (rand_i[15:12] == 4'd0) & ~bird_busy_i;
        rnd_cactus = (rand_i[15:12] == 4'd1) & ~cactus_busy_i;
    end

`ifdef OBSTACLE_SCHED_FORCE_EN
    logic force_due;
    logic pref_bird;

    // Forced spawn after a long armed wait: prefer the type opposite the last grant, fall back to the other
    always_comb begin
        force_due    = ~rnd_bird & ~rnd_cactus & (wait_cnt == 8'(MAX_WAIT_FRAMES - 1));
        pref_bird    = ~last_bird;
        force_bird   = force_due & ~bird_busy_i   & (pref_bird  | cactus_busy_i);
        force_cactus = force_due & ~cactus_busy_i & (~pref_bird | bird_busy_i);
        force_stall  = force_due & ~force_bird & ~force_cactus;
    end
`else
    // Without forcing, only random requests can grant
    always_comb begin
        force_bird   = 1'b0;
        force_cactus = 1'b0;
        force_stall  = 1'b0;
    end
`endif

    assign grant_bird     = rnd_bird   | force_bird;
    assign grant_cactus   = rnd_cactus | force_cactus;
    assign bird_spawn_o   = armed_tick & grant_bird;
    assign cactus_spawn_o = armed_tick & grant_cactus;
    assign level_o        = level;
    assign armed_o        = (state == ARMED);
    assign unused_bits    = ^{rand_i[11:4], 8'(MAX_WAIT_FRAMES)};

    // Scheduler FSM, cooldown/wait counters and level ramp; run_i low returns to reset values
    always_ff @(posedge clk_25_175_i) begin
        if (rst_i || !run_i) begin
            state     <= IDLE;
            gap_cnt   <= 8'(MIN_GAP_INIT);
            wait_cnt  <= 8'd0;
            frame_cnt <= '0;
            level     <= 4'd0;
            last_bird <= 1'b0;
        end else if (!freeze_i) begin
            case (state)
                IDLE: begin
                    state   <= COOLDOWN;
                    gap_cnt <= cur_gap;
                end
                COOLDOWN: begin
                    if (next_frame_i) begin
                        gap_cnt <= gap_cnt - 8'd1;
                        if (gap_cnt <= 8'd1) begin
                            state    <= ARMED;
                            wait_cnt <= 8'd0;
                        end
                    end
                end
                ARMED: begin
                    if (next_frame_i) begin
                        if (grant_bird || grant_cactus) begin
                            last_bird <= grant_bird;
                            gap_cnt   <= cur_gap + {4'd0, rand_i[3:0]};
                            state     <= COOLDOWN;
                        end else if (!force_stall && wait_cnt != 8'hFF) begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Level advances every LEVEL_STEP_FRAMES playing ticks; the new gap applies at the next reload
            if (next_frame_i && state != IDLE) begin
                if (frame_cnt == FC_W'(LEVEL_STEP_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    if (level != 4'd15) begin
                        level <= level + 4'd1;
                    end
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule
